// File: rtl/line_point_counter.sv
// line_point_counter: counts table pairs (x,y) satisfying a*x + b*y == c modulo 2^DATA_W
module line_point_counter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] n_pairs,
   input  logic [DATA_W-1:0] coef_a,
   input  logic [DATA_W-1:0] coef_b,
   input  logic [DATA_W-1:0] coef_c,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  punti_retta,
   output logic              overflow
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] HALF = ADDR_W'(2 ** (ADDR_W - 1));
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_Y, CALC, ACC, DONE} state_t;
   state_t state_q, state_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] ptr_q, ptr_d, pairs_q, pairs_d, n_q, n_d, n_clamp;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, x_q, x_d, y_q, y_d, sum_q, sum_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, res_q, res_d;
   logic              sat_q, sat_d, ovf_q, ovf_d;
   assign busy        = state_q != IDLE;
   assign done        = state_q == DONE;
   assign punti_retta = res_q;
   assign overflow    = ovf_q;
   assign n_clamp     = (n_pairs > HALF) ? HALF : n_pairs;
   always_ff @(posedge clock)
      if (wr_en && !busy) mem_q[wr_addr] <= wr_data;
   // The result registers load on entry to DONE so they are already valid during the done pulse
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      pairs_d = pairs_q;
      n_d     = n_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      x_d     = x_q;
      y_d     = y_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: if (start) begin
            a_d     = coef_a;
            b_d     = coef_b;
            c_d     = coef_c;
            n_d     = n_clamp;
            ptr_d   = '0;
            pairs_d = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
            state_d = (n_clamp == '0) ? DONE : LOAD_X;
            res_d   = (n_clamp == '0) ? '0 : res_q;
            ovf_d   = (n_clamp == '0) ? 1'b0 : ovf_q;
         end
         LOAD_X: begin
            x_d     = mem_q[ptr_q];
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = LOAD_Y;
         end
         LOAD_Y: begin
            y_d     = mem_q[ptr_q];
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = CALC;
         end
         CALC: begin
            sum_d   = a_q * x_q + b_q * y_q;
            state_d = ACC;
         end
         ACC: begin
            cnt_d   = (sum_q == c_q && cnt_q != CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
            sat_d   = sat_q | (sum_q == c_q && cnt_q == CNT_MAX);
            pairs_d = pairs_q + ADDR_W'(1);
            state_d = (pairs_d == n_q) ? DONE : LOAD_X;
            res_d   = (pairs_d == n_q) ? cnt_d : res_q;
            ovf_d   = (pairs_d == n_q) ? sat_d : ovf_q;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         pairs_q <= '0;
         n_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         pairs_q <= pairs_d;
         n_q     <= n_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         x_q     <= x_d;
         y_q     <= y_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
      end
   end
endmodule

// File: doc/line_point_counter.md
Name: line_point_counter

Overview:
- Parametrised successor of the fixed-table line-point checker.
- Scans a writable on-chip table of (x,y) word pairs and counts the pairs that satisfy a programmable line equation a*x + b*y == c, computed modulo 2^DATA_W.
- Adds three things the fixed block lacks: configurable data, depth and counter widths; runtime coefficients; a table write port.
- Sits on the test-pattern datapath and reports its count through a start/busy/done handshake.

Parameters:
- DATA_W, 8: width of table words, coefficients and arithmetic.
- ADDR_W, 4: table address width. DEPTH = 2^ADDR_W words = DEPTH/2 pairs.
- CNT_W, 8: width of the match counter and result.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request a scan; sampled only in IDLE
- n_pairs  in  ADDR_W  number of pairs to scan, sampled with start
- coef_a  in  DATA_W  x coefficient, sampled with start
- coef_b  in  DATA_W  y coefficient, sampled with start
- coef_c  in  DATA_W  target value, sampled with start
- wr_en  in  1  table write strobe; honoured only when busy=0
- wr_addr  in  ADDR_W  table write address
- wr_data  in  DATA_W  table write data
- busy  out  1  high from the cycle after start acceptance through the DONE state
- done  out  1  one-cycle pulse: result valid
- punti_retta  out  CNT_W  match count of the last completed scan
- overflow  out  1  last scan's count saturated

Behaviour:
- Reset (synchronous, on a clock edge with reset=1):
  - state=IDLE.
  - busy=0, done=0, punti_retta=0, overflow=0.
  - Internal pointer, pair counter, x, y, sum and count all cleared.
  - Table contents are not affected by reset.
  - Reset has priority over every other input, including mid-scan; the scan is abandoned and no done pulse is produced.
- Table layout: pair k = (mem[2k], mem[2k+1]).
  - Table reads are combinational from the register array.
  - A write takes effect on the clock edge, so it is visible to reads in the next cycle.
  - wr_en while busy=1 is dropped silently.
- Start acceptance: start=1 in IDLE.
  - Latches coef_a, coef_b, coef_c.
  - Latches N = min(n_pairs, DEPTH/2).
  - Clears pointer and count.
  - Goes to LOAD_X, or to DONE if N==0.
  - start while busy=1 is ignored.
- FSM, 4 cycles per pair:
  - LOAD_X: x <= mem[ptr]; ptr <= ptr+1.
  - LOAD_Y: y <= mem[ptr]; ptr <= ptr+1.
  - CALC: sum <= (a*x + b*y) mod 2^DATA_W. Products and sum are truncated to DATA_W bits.
  - ACC: if sum==c, count <= count+1.
    - Count saturates at 2^CNT_W-1; an increment attempted at saturation sets an internal sat flag.
    - pairs_done+1 == N -> DONE; otherwise -> LOAD_X.
  - DONE: punti_retta <= final count; overflow <= sat; done=1 for exactly this cycle; then -> IDLE.
- Timing:
  - start accepted in cycle T; done high in cycle T+1+4N; busy high from T+1 through T+1+4N.
  - In cycle T+2+4N, busy=0 and a new start is accepted.
- Output holding: punti_retta and overflow hold their value until the next DONE or reset. They are not cleared while idle.
- Pointer wrap: the pointer never exceeds 2N-1 ≤ DEPTH-1, so there is no wrap-around.

Test Plan:
- Matching scan:
  - Stimulus (DATA_W=8): write pairs (1,255), (0,2), (0,0), (5,243); a=3, b=1, c=2; n_pairs=4; start at T.
  - Required: done at T+17 with punti_retta=3, overflow=0; busy=1 over T+1..T+17.
- Zero pairs:
  - Stimulus: n_pairs=0, start.
  - Required: done at T+1, punti_retta=0, busy high only in T+1.
- Counter saturation:
  - Stimulus: CNT_W=2, ADDR_W=4; all 8 pairs = (1,1); a=1, b=1, c=2; n_pairs=8.
  - Required: punti_retta=3, overflow=1, done at T+33.
- Clamping and re-run:
  - Stimulus: ADDR_W=4, n_pairs=12.
  - Required: clamped to 8, so done at T+33.
  - A following run with a matching pair (2,0), a=1, b=0, c=2, n_pairs=1 gives punti_retta=1 and overflow=0.
- Reset mid-scan:
  - Stimulus: assert reset at T+6 of a 4-pair scan.
  - Required: next cycle busy=0, punti_retta=0, no done pulse.
  - A restarted scan then produces the same result as the first scenario.
- Illegal activity while busy:
  - Stimulus: during a scan, pulse start and write wr_addr=1 with 0.
  - Required: done timing unchanged; result unchanged (3 in the first scenario); mem[1] still 255 afterwards.
